// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file / pending-write scoreboard.
package regfile_pkg;

  // Ceiling log2 with a floor of 1 so single-entry structures still get a bit.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned res;
    res = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) res = i + 1;
    end
    return res;
  endfunction

  localparam int unsigned XLEN_DEF     = 32;
  localparam int unsigned NREGS_DEF    = 32;
  localparam int unsigned NRD_DEF      = 2;
  localparam int unsigned PEND_MAX_DEF = 3;
  localparam int unsigned AW_DEF       = clog2(NREGS_DEF);
  localparam int unsigned CW_DEF       = clog2(PEND_MAX_DEF + 1);
  localparam int unsigned ZERO_IDX     = 0;

endpackage

// File: rtl/regfile_pend_ctr.sv
// Per-register count of issued-but-unretired writes, with registered status flags.
module regfile_pend_ctr
  import regfile_pkg::*;
#(
  parameter int unsigned CW       = CW_DEF,
  parameter int unsigned PEND_MAX = PEND_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic dec,
  input  logic flush,
  output logic busy,
  output logic at_max,
  output logic last
);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          inc_ok;
  logic          dec_ok;

  // Guards keep the counter inside [0, PEND_MAX] even if the caller misbehaves.
  assign inc_ok = inc && !at_max;
  assign dec_ok = dec && busy;

  always_comb begin
    cnt_nxt = cnt;
    if (flush) begin
      cnt_nxt = '0;
    end else if (inc_ok && !dec_ok) begin
      cnt_nxt = cnt + CW'(1);
    end else if (dec_ok && !inc_ok) begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  // Flags are derived from the next count so they come straight out of flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      busy   <= 1'b0;
      at_max <= 1'b0;
      last   <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      busy   <= (cnt_nxt != '0);
      at_max <= (cnt_nxt == CW'(PEND_MAX));
      last   <= (cnt_nxt == CW'(1));
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-read-port integer register file with a per-register pending-write scoreboard,
// optional write-through bypass and a hardwired zero register.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN     = XLEN_DEF,
  parameter int unsigned NREGS    = NREGS_DEF,
  parameter int unsigned NRD      = NRD_DEF,
  parameter int unsigned PEND_MAX = PEND_MAX_DEF,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NRD*clog2(NREGS)-1:0] rd_idx,
  output logic [NRD*XLEN-1:0]    rd_data,
  output logic [NRD-1:0]         rd_busy,
  input  logic                   iss_en,
  input  logic [clog2(NREGS)-1:0] iss_idx,
  output logic                   iss_ready,
  input  logic                   wr_en,
  input  logic [clog2(NREGS)-1:0] wr_idx,
  input  logic [XLEN-1:0]        wr_data,
  input  logic                   flush,
  output logic                   err
);

  localparam int unsigned AW = clog2(NREGS);
  localparam int unsigned CW = clog2(PEND_MAX + 1);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] pend_busy;
  logic [NREGS-1:0] pend_at_max;
  logic [NREGS-1:0] pend_last;
  logic             wr_zero;
  logic             iss_go;

  assign wr_zero   = (ZERO_REG != 0) && (wr_idx == AW'(ZERO_IDX));
  assign iss_ready = rst || !pend_at_max[iss_idx];
  // Flush squashes any issue arriving in the same cycle.
  assign iss_go    = iss_en && iss_ready && !flush;

  // Data array; the zero register is simply never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en && !wr_zero) begin
      regs[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (iss_en && !iss_ready) begin
      err <= 1'b1;
    end
  end

  genvar r;
  generate
    for (r = 0; r < NREGS; r++) begin : g_pend
      if ((ZERO_REG != 0) && (r == ZERO_IDX)) begin : g_zero
        assign pend_busy[r]   = 1'b0;
        assign pend_at_max[r] = 1'b0;
        assign pend_last[r]   = 1'b0;
      end else begin : g_ctr
        regfile_pend_ctr #(
          .CW       (CW),
          .PEND_MAX (PEND_MAX)
        ) u_ctr (
          .clk    (clk),
          .rst    (rst),
          .inc    (iss_go && (iss_idx == AW'(r))),
          .dec    (wr_en && (wr_idx == AW'(r))),
          .flush  (flush),
          .busy   (pend_busy[r]),
          .at_max (pend_at_max[r]),
          .last   (pend_last[r])
        );
      end
    end
  endgenerate

  // Read ports: a retiring final write both forwards its data and clears busy.
  genvar p;
  generate
    for (p = 0; p < NRD; p++) begin : g_rd
      logic [AW-1:0] idx;
      logic          zero;
      logic          hit;

      assign idx  = rd_idx[p*AW +: AW];
      assign zero = (ZERO_REG != 0) && (idx == AW'(ZERO_IDX));
      assign hit  = (BYPASS != 0) && wr_en && (wr_idx == idx) && !zero;

      assign rd_data[p*XLEN +: XLEN] = (rst || zero) ? '0 :
                                       hit           ? wr_data : regs[idx];
      assign rd_busy[p] = !rst && !zero && pend_busy[idx] && !(hit && pend_last[idx]);
    end
  endgenerate

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: bypassing and non-bypassing instances share stimulus.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_idx;
  logic        iss_en;
  logic [4:0]  iss_idx;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [31:0] wr_data;
  logic        flush;

  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        iss_ready;
  logic        err;

  logic [63:0] nb_rd_data;
  logic [1:0]  nb_rd_busy;
  logic        nb_iss_ready;
  logic        nb_err;

  int n_checks;
  int n_errors;

  regfile_scoreboard #(.BYPASS(1)) dut (
    .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_data(rd_data), .rd_busy(rd_busy),
    .iss_en(iss_en), .iss_idx(iss_idx), .iss_ready(iss_ready),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .flush(flush), .err(err)
  );

  regfile_scoreboard #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rd_idx(rd_idx), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
    .iss_en(iss_en), .iss_idx(iss_idx), .iss_ready(nb_iss_ready),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .flush(flush), .err(nb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_en = 1'b0;
    wr_en  = 1'b0;
    flush  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    rd_idx = '0; iss_idx = '0; wr_idx = '0; wr_data = '0;
    idle();
    #12;
    check("rst_iss_ready", 64'(iss_ready), 64'd1);
    check("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    step();

    // 1: everything reads zero and idle after reset
    for (int i = 0; i < 32; i++) begin
      rd_idx = {5'(i), 5'(31 - i)};
      #1;
      check($sformatf("t1_data_%0d", i), rd_data, 64'd0);
      check($sformatf("t1_busy_%0d", i), 64'(rd_busy), 64'd0);
    end
    check("t1_iss_ready", 64'(iss_ready), 64'd1);
    check("t1_err", 64'(err), 64'd0);

    // 2: same-cycle bypass vs next-cycle visibility
    rd_idx = {5'd0, 5'd5};
    wr_en = 1'b1; wr_idx = 5'd5; wr_data = 32'hDEADBEEF;
    #1;
    check("t2_byp_same", 64'(rd_data[31:0]), 64'hDEADBEEF);
    check("t2_nb_same", 64'(nb_rd_data[31:0]), 64'h0);
    step();
    idle();
    #1;
    check("t2_byp_next", 64'(rd_data[31:0]), 64'hDEADBEEF);
    check("t2_nb_next", 64'(nb_rd_data[31:0]), 64'hDEADBEEF);

    // 3: saturate x7, overflow issue, then drain
    rd_idx = {5'd0, 5'd7};
    iss_en = 1'b1; iss_idx = 5'd7;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t3_ready_%0d", k), 64'(iss_ready), 64'd1);
      step();
    end
    check("t3_ready_full", 64'(iss_ready), 64'd0);
    check("t3_busy_full", 64'(rd_busy[0]), 64'd1);
    check("t3_err_before", 64'(err), 64'd0);
    step();
    idle();
    #1;
    check("t3_err_set", 64'(err), 64'd1);
    check("t3_ready_still0", 64'(iss_ready), 64'd0);
    wr_en = 1'b1; wr_idx = 5'd7;
    for (int k = 1; k <= 3; k++) begin
      wr_data = 32'(k);
      #1;
      check($sformatf("t3_wb_busy_%0d", k), 64'(rd_busy[0]), (k == 3) ? 64'd0 : 64'd1);
      check($sformatf("t3_nb_wb_busy_%0d", k), 64'(nb_rd_busy[0]), 64'd1);
      step();
    end
    idle();
    #1;
    check("t3_drained_busy", 64'(rd_busy[0]), 64'd0);
    check("t3_nb_drained_busy", 64'(nb_rd_busy[0]), 64'd0);
    check("t3_drained_data", 64'(rd_data[31:0]), 64'd3);
    check("t3_drained_ready", 64'(iss_ready), 64'd1);

    // 4: simultaneous issue and writeback leaves the count unchanged
    rd_idx = {5'd0, 5'd9};
    iss_en = 1'b1; iss_idx = 5'd9;
    step();
    wr_en = 1'b1; wr_idx = 5'd9; wr_data = 32'h99;
    #1;
    check("t4_ready", 64'(iss_ready), 64'd1);
    step();
    idle();
    #1;
    check("t4_busy_kept", 64'(rd_busy[0]), 64'd1);
    check("t4_data", 64'(rd_data[31:0]), 64'h99);
    wr_en = 1'b1; wr_data = 32'h9A;
    step();
    idle();
    #1;
    check("t4_busy_retired", 64'(rd_busy[0]), 64'd0);
    check("t4_data2", 64'(rd_data[31:0]), 64'h9A);

    // 5: flush clears pending state, discards same-cycle issue, keeps the write
    iss_en = 1'b1; iss_idx = 5'd3;
    step();
    iss_idx = 5'd4;
    step();
    idle();
    rd_idx = {5'd4, 5'd3};
    #1;
    check("t5_busy_pre", 64'(rd_busy), 64'b11);
    flush = 1'b1; iss_en = 1'b1; iss_idx = 5'd6;
    wr_en = 1'b1; wr_idx = 5'd3; wr_data = 32'h33;
    step();
    idle();
    #1;
    check("t5_busy_post", 64'(rd_busy), 64'b00);
    check("t5_nb_busy_post", 64'(nb_rd_busy), 64'b00);
    check("t5_data_x3", 64'(rd_data[31:0]), 64'h33);
    rd_idx = {5'd6, 5'd3};
    #1;
    check("t5_busy_x6", 64'(rd_busy[1]), 64'd0);

    // 6: zero register, then mid-sequence reset
    rd_idx = {5'd0, 5'd0};
    wr_en = 1'b1; wr_idx = 5'd0; wr_data = 32'hFFFFFFFF;
    iss_en = 1'b1; iss_idx = 5'd0;
    #1;
    check("t6_x0_byp", rd_data, 64'd0);
    check("t6_x0_ready", 64'(iss_ready), 64'd1);
    step();
    idle();
    #1;
    check("t6_x0_data", rd_data, 64'd0);
    check("t6_x0_busy", 64'(rd_busy), 64'd0);
    check("t6_err_sticky", 64'(err), 64'd1);
    iss_en = 1'b1; iss_idx = 5'd7;
    step();
    idle();
    rd_idx = {5'd7, 5'd5};
    #1;
    check("t6_busy_pre", 64'(rd_busy), 64'b10);
    check("t6_data_pre", 64'(rd_data[31:0]), 64'hDEADBEEF);
    wr_en = 1'b1; wr_idx = 5'd5; wr_data = 32'h55;
    iss_en = 1'b1; iss_idx = 5'd7;
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_data", rd_data, 64'd0);
    check("t6_rst_busy", 64'(rd_busy), 64'd0);
    check("t6_rst_err", 64'(err), 64'd0);
    check("t6_rst_ready", 64'(iss_ready), 64'd1);
    #2;
    rst = 1'b0;
    idle();
    step();
    check("t6_post_data", 64'(rd_data[31:0]), 64'd0);
    check("t6_post_busy", 64'(rd_busy), 64'd0);
    iss_en = 1'b1; iss_idx = 5'd7;
    step();
    idle();
    #1;
    check("t6_post_issue", 64'(rd_busy), 64'b10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
